// File: rtl/hidden_cpu_pkg.sv
// Shared definitions for the hidden CPU instruction feeder.
// Contents:
//   INSTR_W            - instruction word width (maps to CPU io_in[7:2])
//   OP_*/ADDR_A_*/ADDR_B_* - field positions inside an instruction word
//   IDLE_INSTR         - word driven when no program word is being issued
//   state_t            - feeder FSM state encoding
//   make_instr()       - packs opcode/addrA/addrB into an instruction word
package hidden_cpu_pkg;

  localparam int INSTR_W = 6;

  localparam int OP_HI     = 5;
  localparam int OP_LO     = 4;
  localparam int ADDR_A_HI = 3;
  localparam int ADDR_A_LO = 2;
  localparam int ADDR_B_HI = 1;
  localparam int ADDR_B_LO = 0;

  localparam logic [INSTR_W-1:0] IDLE_INSTR = 6'b000000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_CAPTURE = 2'd2
  } state_t;

  function automatic logic [INSTR_W-1:0] make_instr(input logic [1:0] op,
                                                    input logic [1:0] addr_a,
                                                    input logic [1:0] addr_b);
    logic [INSTR_W-1:0] w;
    w = '0;
    w[OP_HI:OP_LO]         = op;
    w[ADDR_A_HI:ADDR_A_LO] = addr_a;
    w[ADDR_B_HI:ADDR_B_LO] = addr_b;
    return w;
  endfunction

endpackage

// File: rtl/prog_mem.sv
// Program buffer: DEPTH x W storage, one synchronous write port and one
// asynchronous read port. Contents are not reset.
// Ports:
//   clk   - clock
//   we    - write enable
//   waddr - write address
//   wdata - write data
//   raddr - read address
//   rdata - read data (combinational from raddr)
module prog_mem #(
  parameter int DEPTH = 16,
  parameter int W     = 6,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/hidden_cpu_feeder.sv
// Host-side instruction streamer for the hidden CPU.
// Buffers a program loaded over a valid/ready port, holds the CPU in reset
// while idle, streams one word per clock on start and captures the CPU
// output bus one cycle after the last word.
// Ports:
//   clk, rst             - clock, synchronous active-high reset
//   clear                - synchronous flush of the program and abort of a run
//   load_valid/load_data/load_ready - program load port
//   start                - request a run of the buffered program
//   busy                 - high in RUN or CAPTURE
//   instr_out/instr_valid - instruction stream to CPU io_in[7:2]
//   cpu_rst              - CPU reset, io_in[1]
//   cpu_out              - CPU io_out
//   result/result_valid  - captured cpu_out of the last completed run
//
// Load handshake: a word transfers on a rising clk edge where load_valid and
// load_ready are both high; load_ready does not depend on load_valid, and an
// offered word stays pending (never dropped) until it is accepted.
module hidden_cpu_feeder #(
  parameter int                  DEPTH      = 16,
  parameter int                  INSTR_W    = hidden_cpu_pkg::INSTR_W,
  parameter logic [INSTR_W-1:0]  IDLE_INSTR = hidden_cpu_pkg::IDLE_INSTR
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               load_valid,
  input  logic [INSTR_W-1:0] load_data,
  output logic               load_ready,
  input  logic               start,
  output logic               busy,
  output logic [INSTR_W-1:0] instr_out,
  output logic               instr_valid,
  output logic               cpu_rst,
  input  logic [7:0]         cpu_out,
  output logic [7:0]         result,
  output logic               result_valid
);

  import hidden_cpu_pkg::*;

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  state_t             state;
  logic [CNT_W-1:0]   count;
  logic [AW-1:0]      rd_ptr;    // index of the word currently on instr_out
  logic [AW-1:0]      rd_addr;
  logic [INSTR_W-1:0] rd_data;
  logic               wr_en;
  logic               last_word;

  // start and clear take priority over a load in the same cycle, so the
  // port is closed in that cycle rather than accepting a word it would lose.
  assign load_ready = (state == ST_IDLE) && (count < CNT_W'(DEPTH)) && !start && !clear;
  assign wr_en      = load_valid && load_ready && !rst;

  // Look-ahead read: in IDLE the next word to issue is word 0, in RUN it is
  // the one after the word currently on the bus. Wraps naturally at DEPTH.
  assign rd_addr   = (state == ST_RUN) ? rd_ptr + AW'(1) : '0;
  assign last_word = ({1'b0, rd_ptr} == count - CNT_W'(1));

  prog_mem #(
    .DEPTH (DEPTH),
    .W     (INSTR_W),
    .AW    (AW)
  ) u_prog_mem (
    .clk   (clk),
    .we    (wr_en),
    .waddr (count[AW-1:0]),
    .wdata (load_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      count        <= '0;
      rd_ptr       <= '0;
      busy         <= 1'b0;
      instr_out    <= IDLE_INSTR;
      instr_valid  <= 1'b0;
      cpu_rst      <= 1'b1;
      result       <= 8'h00;
      result_valid <= 1'b0;
    end else if (clear) begin
      // result is kept; result_valid going low marks it stale.
      state        <= ST_IDLE;
      count        <= '0;
      rd_ptr       <= '0;
      busy         <= 1'b0;
      instr_out    <= IDLE_INSTR;
      instr_valid  <= 1'b0;
      cpu_rst      <= 1'b1;
      result_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start && (count != '0)) begin
            // CPU saw cpu_rst=1 at this edge, so it begins from reset.
            state        <= ST_RUN;
            rd_ptr       <= '0;
            busy         <= 1'b1;
            instr_out    <= rd_data;
            instr_valid  <= 1'b1;
            cpu_rst      <= 1'b0;
            result_valid <= 1'b0;
          end else if (wr_en) begin
            count <= count + CNT_W'(1);
          end
        end
        ST_RUN: begin
          if (last_word) begin
            state       <= ST_CAPTURE;
            rd_ptr      <= '0;
            instr_out   <= IDLE_INSTR;
            instr_valid <= 1'b0;
          end else begin
            rd_ptr    <= rd_ptr + AW'(1);
            instr_out <= rd_data;
          end
        end
        ST_CAPTURE: begin
          // cpu_out now reflects the CPU state after the last instruction.
          state        <= ST_IDLE;
          result       <= cpu_out;
          result_valid <= 1'b1;
          busy         <= 1'b0;
          cpu_rst      <= 1'b1;
        end
        default: begin
          state       <= ST_IDLE;
          busy        <= 1'b0;
          instr_out   <= IDLE_INSTR;
          instr_valid <= 1'b0;
          cpu_rst     <= 1'b1;
        end
      endcase
    end
  end

endmodule
